sword_anim_ctrl: RTL and testbench

SWORD_ANIM_CTRL -- requirements
Module: sword_anim_ctrl

---
 rtl/sword_anim_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sword_anim_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sword_anim_ctrl.sv
// sword_anim_ctrl
// Sequences a sword attack through windup, swing, hold, recover and cooldown,
// timed in video frames. It also produces the address and pixel qualifier
// for a 32x32 sword sprite ROM that is placed next to the player sprite.
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | no attack; waiting for an attack button edge
// WINDUP   | sword raised, not yet able to hit
// SWING    | sword moving, hit window open
// HOLD     | sword extended, hit window open
// RECOVER  | sword returning, hit window closed
// COOLDOWN | sword hidden, new attacks still refused
//
// Ports
//   vga_clk        sole clock
//   Reset          synchronous, active-high reset
//   frame_tick     one-cycle pulse per video frame
//   attack_req     attack button level
//   dir_in         facing direction (0 up, 1 down, 2 left, 3 right)
//   link_x/link_y  top-left corner of the player sprite
//   DrawX/DrawY    current pixel
//   busy           any state other than IDLE
//   sword_visible  WINDUP, SWING, HOLD, RECOVER
//   hit_window     SWING, HOLD
//   frame_sel      sword ROM/palette selector
//   dir_out        direction latched when the attack was accepted
//   rom_address    combinational sword ROM address
//   pixel_valid    in-box qualifier delayed to match the ROM read latency
module sword_anim_ctrl #(
    parameter int WINDUP_FRAMES   = 2,
    parameter int SWING_FRAMES    = 4,
    parameter int HOLD_FRAMES     = 6,
    parameter int RECOVER_FRAMES  = 2,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       attack_req,
    input  logic [1:0] dir_in,
    input  logic [9:0] link_x,
    input  logic [9:0] link_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       busy,
    output logic       sword_visible,
    output logic       hit_window,
    output logic [1:0] frame_sel,
    output logic [1:0] dir_out,
    output logic [9:0] rom_address,
    output logic       pixel_valid
);

    typedef enum logic [2:0] {
        S_IDLE, S_WINDUP, S_SWING, S_HOLD, S_RECOVER, S_COOLDOWN
    } state_t;

    localparam logic [3:0] WINDUP_LAST   = 4'(WINDUP_FRAMES - 1);
    localparam logic [3:0] SWING_LAST    = 4'(SWING_FRAMES - 1);
    localparam logic [3:0] HOLD_LAST     = 4'(HOLD_FRAMES - 1);
    localparam logic [3:0] RECOVER_LAST  = 4'(RECOVER_FRAMES - 1);
    localparam logic [3:0] COOLDOWN_LAST = 4'(COOLDOWN_FRAMES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  dir_q, dir_d;
    logic        attack_prev_q, attack_prev_d;
    logic        pv_q, pv_d;

    logic        attack_edge;
    logic [3:0]  last_cnt;
    state_t      state_succ;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            dir_q         <= 2'd3;
            // Treat the button as already pressed so a hold through reset
            // cannot look like a fresh edge.
            attack_prev_q <= 1'b1;
            pv_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            attack_prev_q <= attack_prev_d;
            pv_q          <= pv_d;
        end
    end

    assign attack_edge = attack_req & ~attack_prev_q;

    always_comb begin
        last_cnt   = 4'd0;
        state_succ = S_IDLE;
        case (state_q)
            S_WINDUP:   begin last_cnt = WINDUP_LAST;   state_succ = S_SWING;    end
            S_SWING:    begin last_cnt = SWING_LAST;    state_succ = S_HOLD;     end
            S_HOLD:     begin last_cnt = HOLD_LAST;     state_succ = S_RECOVER;  end
            S_RECOVER:  begin last_cnt = RECOVER_LAST;  state_succ = S_COOLDOWN; end
            S_COOLDOWN: begin last_cnt = COOLDOWN_LAST; state_succ = S_IDLE;     end
            default:    begin last_cnt = 4'd0;          state_succ = S_IDLE;     end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dir_d         = dir_q;
        attack_prev_d = attack_req;
        if (state_q == S_IDLE) begin
            // A frame tick arriving with the accepting edge is dropped here,
            // so WINDUP always gets its full frame count.
            cnt_d = 4'd0;
            if (attack_edge) begin
                state_d = S_WINDUP;
                dir_d   = dir_in;
            end
        end else if (frame_tick) begin
            if (cnt_q == last_cnt) begin
                cnt_d   = 4'd0;
                state_d = state_succ;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        busy          = (state_q != S_IDLE);
        sword_visible = 1'b0;
        hit_window    = 1'b0;
        frame_sel     = 2'd0;
        case (state_q)
            S_WINDUP:  begin sword_visible = 1'b1; frame_sel = 2'd0; end
            S_SWING:   begin sword_visible = 1'b1; hit_window = 1'b1; frame_sel = 2'd1; end
            S_HOLD:    begin sword_visible = 1'b1; hit_window = 1'b1; frame_sel = 2'd2; end
            S_RECOVER: begin sword_visible = 1'b1; frame_sel = 2'd1; end
            default:   begin sword_visible = 1'b0; frame_sel = 2'd0; end
        endcase
    end

    // Sword box geometry, 11 bits wide so off-screen placement is visible.
    logic [10:0] lx, ly, bx, by, bx_end, by_end, px, py;
    logic        under, suppress, in_box;
    logic [4:0]  dx, dy;

    always_comb begin
        lx    = {1'b0, link_x};
        ly    = {1'b0, link_y};
        px    = {1'b0, DrawX};
        py    = {1'b0, DrawY};
        bx    = lx;
        by    = ly;
        under = 1'b0;
        case (dir_q)
            2'd0: begin by = ly - 11'd32; under = (ly < 11'd32); end
            2'd1: begin by = ly + 11'd32; end
            2'd2: begin bx = lx - 11'd32; under = (lx < 11'd32); end
            default: begin bx = lx + 11'd32; end
        endcase
        bx_end   = bx + 11'd32;
        by_end   = by + 11'd32;
        suppress = under | (bx_end > 11'd640) | (by_end > 11'd480);
        in_box   = sword_visible & ~suppress
                 & (px >= bx) & (px < bx_end)
                 & (py >= by) & (py < by_end);
        // Only the low five bits of the in-box offset are ever non-zero.
        dx          = DrawX[4:0] - bx[4:0];
        dy          = DrawY[4:0] - by[4:0];
        rom_address = in_box ? {dy, dx} : 10'd0;
        pv_d        = in_box;
    end

    assign dir_out     = dir_q;
    assign pixel_valid = pv_q;

endmodule

// File: tb/tb_sword_anim_ctrl.sv
module tb_sword_anim_ctrl;

    logic       vga_clk;
    logic       Reset;
    logic       frame_tick;
    logic       attack_req;
    logic [1:0] dir_in;
    logic [9:0] link_x, link_y, DrawX, DrawY;
    logic       busy, sword_visible, hit_window, pixel_valid;
    logic [1:0] frame_sel, dir_out;
    logic [9:0] rom_address;

    sword_anim_ctrl dut (
        .vga_clk       (vga_clk),
        .Reset         (Reset),
        .frame_tick    (frame_tick),
        .attack_req    (attack_req),
        .dir_in        (dir_in),
        .link_x        (link_x),
        .link_y        (link_y),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .busy          (busy),
        .sword_visible (sword_visible),
        .hit_window    (hit_window),
        .frame_sel     (frame_sel),
        .dir_out       (dir_out),
        .rom_address   (rom_address),
        .pixel_valid   (pixel_valid)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Observable selectors: 0 state code {busy,vis,hit,frame_sel},
    // 1 dir_out, 2 rom_address, 3 pixel_valid.
    typedef struct {
        string name;
        int    sig;
        int    exp;
    } chk_t;

    chk_t q[$];
    int   total = 0;
    int   bad   = 0;

    // State after k frame ticks of an attack (index 0 = just accepted).
    string seq = "WWSSSSHHHHHHRRCCCCCCCCI";

    function automatic int code_of(input byte c);
        case (c)
            "W":     return 24;  // 1 1 0 00
            "S":     return 29;  // 1 1 1 01
            "H":     return 30;  // 1 1 1 10
            "R":     return 25;  // 1 1 0 01
            "C":     return 16;  // 1 0 0 00
            default: return 0;   // IDLE
        endcase
    endfunction

    function automatic int dut_val(input int sig);
        case (sig)
            0:       return int'({busy, sword_visible, hit_window, frame_sel});
            1:       return int'(dir_out);
            2:       return int'(rom_address);
            default: return int'(pixel_valid);
        endcase
    endfunction

    // Monitor: drains expectations at each falling edge.
    initial begin
        chk_t c;
        int   act;
        forever begin
            @(negedge vga_clk);
            while (q.size() > 0) begin
                c   = q.pop_front();
                act = dut_val(c.sig);
                total++;
                if (act != c.exp) begin
                    bad++;
                    $display("FAIL %s actual=%0d expected=%0d", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge vga_clk);
        #2;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic expect_v(input string n, input int sig, input int v);
        chk_t c;
        c.name = n;
        c.sig  = sig;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic expect_st(input string n, input int k);
        expect_v(n, 0, code_of(seq[k]));
    endtask

    task automatic run_ticks(input string n, input int from, input int to);
        for (int k = from + 1; k <= to; k++) begin
            tick();
            expect_st($sformatf("%s_t%0d", n, k), k);
        end
    endtask

    task automatic press();
        attack_req = 1'b0;
        cyc();
        attack_req = 1'b1;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; attack_req = 1'b0; dir_in = 2'd0;
        link_x = 10'd100; link_y = 10'd200; DrawX = 10'd0; DrawY = 10'd0;
        cyc(); cyc();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy_direct actual=%0d expected=0", busy);
        end
        total++;
        if (dir_out !== 2'd3) begin
            bad++;
            $display("FAIL rst_dir_direct actual=%0d expected=3", dir_out);
        end
        expect_v("rst_state", 0, 0);
        expect_v("rst_dir", 1, 3);
        expect_v("rst_pv", 3, 0);
        Reset = 1'b0;
        cyc();
        expect_v("post_rst_idle", 0, 0);

        // basic attack
        dir_in = 2'd2;
        press();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy_direct actual=%0d expected=1", busy);
        end
        total++;
        if (dir_out !== 2'd2) begin
            bad++;
            $display("FAIL basic_dir_direct actual=%0d expected=2", dir_out);
        end
        expect_st("basic_t0", 0);
        expect_v("basic_dir", 1, 2);
        attack_req = 1'b0; dir_in = 2'd0;
        run_ticks("basic", 0, 22);
        cyc();
        expect_v("basic_dir_hold", 1, 2);
        expect_st("basic_idle", 22);

        // held button, with a tick on the accepting edge
        attack_req = 1'b0; cyc();
        dir_in = 2'd1; attack_req = 1'b1; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        total++;
        if (dir_out !== 2'd1) begin
            bad++;
            $display("FAIL held_dir_direct actual=%0d expected=1", dir_out);
        end
        expect_st("held_t0", 0);
        expect_v("held_dir", 1, 1);
        run_ticks("held", 0, 22);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_st($sformatf("held_extra%0d", i), 22);
        end
        attack_req = 1'b0; cyc();
        expect_st("held_release", 22);
        attack_req = 1'b1; cyc();
        expect_st("held_second", 0);
        attack_req = 1'b0;
        run_ticks("second", 0, 22);

        // edges while busy
        press();
        expect_st("busy_t0", 0);
        attack_req = 1'b0;
        run_ticks("busy", 0, 3);
        attack_req = 1'b1; cyc();
        expect_st("busy_edge_swing", 3);
        attack_req = 1'b0; cyc();
        run_ticks("busy", 3, 16);
        attack_req = 1'b1; cyc();
        expect_st("busy_edge_cool", 16);
        attack_req = 1'b0;
        run_ticks("busy", 16, 22);
        cyc(); cyc();
        expect_st("busy_no_queue", 22);

        // geometry, facing right
        dir_in = 2'd3; link_x = 10'd100; link_y = 10'd200;
        DrawX = 10'd164; DrawY = 10'd200;
        expect_v("geo_idle_rom", 2, 0);
        press();
        attack_req = 1'b0;
        run_ticks("geo", 0, 2);
        expect_v("geo_pv_out", 3, 0);
        expect_v("geo_rom_out", 2, 0);
        cyc();
        DrawX = 10'd132;
        expect_v("geo_rom_origin", 2, 0);
        expect_v("geo_pv_lat", 3, 0);
        cyc();
        expect_v("geo_pv_origin", 3, 1);
        DrawX = 10'd163; DrawY = 10'd231;
        expect_v("geo_rom_corner", 2, 1023);
        cyc();
        expect_v("geo_pv_corner", 3, 1);
        DrawX = 10'd132; DrawY = 10'd205;
        expect_v("geo_rom_row5", 2, 160);
        cyc();
        link_x = 10'd576; DrawX = 10'd639; DrawY = 10'd200;
        expect_v("geo_rom_edge640", 2, 31);
        cyc();
        expect_v("geo_pv_edge640", 3, 1);
        link_x = 10'd577;
        expect_v("geo_rom_over640", 2, 0);
        cyc();
        expect_v("geo_pv_over640", 3, 0);
        link_x = 10'd100; DrawX = 10'd164; DrawY = 10'd200;
        expect_v("geo_rom_x164", 2, 0);
        cyc();
        expect_v("geo_pv_x164", 3, 0);
        run_ticks("geo", 2, 22);

        // left-facing underflow
        dir_in = 2'd2; link_x = 10'd10; link_y = 10'd200;
        press();
        attack_req = 1'b0;
        run_ticks("uf", 0, 2);
        for (int x = 0; x < 48; x += 6) begin
            DrawX = 10'(x); DrawY = 10'd210;
            expect_v($sformatf("uf_rom_x%0d", x), 2, 0);
            cyc();
            expect_v($sformatf("uf_pv_x%0d", x), 3, 0);
        end
        run_ticks("uf", 2, 22);

        // reset in HOLD with the button held
        dir_in = 2'd3; link_x = 10'd100; link_y = 10'd200;
        DrawX = 10'd132; DrawY = 10'd200;
        press();
        run_ticks("rst", 0, 6);
        expect_v("rst_pv_hold", 3, 1);
        expect_v("rst_dir_hold", 1, 3);
        dir_in = 2'd0;
        Reset = 1'b1; cyc();
        expect_v("rstmid_state", 0, 0);
        expect_v("rstmid_dir", 1, 3);
        expect_v("rstmid_pv", 3, 0);
        expect_v("rstmid_rom", 2, 0);
        Reset = 1'b0; cyc();
        expect_v("rstmid_after", 0, 0);
        cyc(); cyc();
        expect_v("rstmid_held", 0, 0);
        attack_req = 1'b0; cyc();
        expect_v("rstmid_release", 0, 0);
        attack_req = 1'b1; cyc();
        expect_st("rstmid_repress", 0);
        expect_v("rstmid_newdir", 1, 0);
        attack_req = 1'b0;
        Reset = 1'b1; cyc();
        Reset = 1'b0; cyc();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL final_busy_direct actual=%0d expected=0", busy);
        end
        expect_v("final_idle", 0, 0);
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
